cross_bar_arbiter_rr_mx1: RTL
=============================

Name: cross_bar_arbiter_rr_mx1

Overview:
- Packet-level round-robin arbiter that merges CHANNEL_NO AXI-Stream slaves onto one AXI-Stream master.
- Successor to the Mx1 crossbar arbiter, with four changes: any channel count (not only powers of two), single-cycle lookahead grant that skips idle channels, a registered 2-entry skid output stage, and optional source-ID tagging.
- Sits at each crossbar output port and feeds the downstream sink.

Parameters:
- CHANNEL_NO, 4, number of slave inputs; legal values 2..32.
- MSEL_WIDTH, $clog2(CHANNEL_NO), width of the channel index (derived; do not override).
- DATA_WIDTH, 32, tdata width in bits; legal values 1..1024.

Ports:
- aclk  input  1  clock; all logic is on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  DATA_WIDTH x [CHANNEL_NO]  slave data, one per channel.
- s_axis_tvalid  input  1 x [CHANNEL_NO]  slave valid.
- s_axis_tlast  input  1 x [CHANNEL_NO]  slave end-of-packet.
- s_axis_tready  output  1 x [CHANNEL_NO]  slave ready.
- m_axis_tdata  output  DATA_WIDTH  master data, registered.
- m_axis_tvalid  output  1  master valid, registered.
- m_axis_tlast  output  1  master end-of-packet, registered.
- m_axis_tready  input  1  master ready.
- m_axis_tid  output  MSEL_WIDTH  source channel index; present only when CROSS_BAR_ARB_TID_EN is defined.

Behaviour:
- Reset (aresetn=0, takes effect immediately, no clock needed):
  - state=IDLE, last-grant pointer ptr=CHANNEL_NO-1, grant index=0.
  - Skid buffer empty; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 (m_axis_tid=0 when enabled).
  - All s_axis_tready=0.
- FSM states are IDLE and ACTIVE. Unreachable encodings go to IDLE with reset values.
- IDLE:
  - If any s_axis_tvalid is high, grant the first requesting channel found searching ptr+1, ptr+2, ... with modulo-CHANNEL_NO wrap. The search completes in one cycle.
  - Register the grant index and one-hot select, then go ACTIVE.
  - With no request, stay in IDLE and leave ptr unchanged.
- ACTIVE:
  - s_axis_tready[g] = skid-not-full, taken from a register (no combinational path from m_axis_tready).
  - All other s_axis_tready = 0.
  - On a handshake with s_axis_tlast[g]=1: ptr<=g, go IDLE.
  - If the granted channel drops tvalid mid-packet, the grant is held indefinitely; there is no timeout.
- Arbitration gap: exactly one IDLE cycle separates the last beat of one packet from the first beat of the next on the input side. A continuously requesting single channel is re-granted after that one cycle.
- Fairness: with all channels requesting, grants rotate 0,1,...,CHANNEL_NO-1,0,...
- Skid buffer:
  - 2 entries, FIFO order; each entry holds {tdata, tlast[, tid]}.
  - An input handshake at edge N makes the beat visible on m_axis at cycle N+1 if the buffer was empty.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Ready deasserts when occupancy reaches 2 after the edge.
  - m_axis_tvalid = occupancy != 0. The head entry stays stable while m_axis_tvalid=1 and m_axis_tready=0.
- Input data from non-granted channels never reaches the output.
- Throughput: 1 beat/cycle sustained while m_axis_tready=1.
- Reset mid-packet: any partial packet in the skid buffer is discarded; the next grant starts from channel 0.

Optional Feature:
- Macro: CROSS_BAR_ARB_TID_EN.
- Defined: the m_axis_tid port exists. Each skid entry stores the grant index at push time, and m_axis_tid equals the source channel of the beat on m_axis.
- Undefined: there is no m_axis_tid port, no tid storage, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle for 10 cycles -> m_axis_tvalid=0, all s_axis_tready=0, no state change.
- Channels 0-3 each hold one 3-beat packet with tdata=0xC0..0xC2 + 0x10*ch, m_axis_tready=1 -> output order ch0,ch1,ch2,ch3; 12 beats; each tlast on the 3rd beat; one-cycle input gap between packets.
- Only ch2 requests, from reset (ptr=3) -> ch2 granted in the first IDLE cycle with no rotation delay; the first beat appears on m_axis 2 cycles after tvalid rises.
- m_axis_tready=0 during a 5-beat ch1 packet -> exactly 2 beats accepted and s_axis_tready[1] falls. Then m_axis_tready=1 -> all 5 beats are delivered in order without loss or duplication.
- ch0 drops tvalid for 4 cycles mid-packet while ch3 requests -> ch0 keeps the grant, s_axis_tready[3]=0 throughout, and ch3 is served only after ch0's tlast.
- aresetn pulsed low mid-packet with CROSS_BAR_ARB_TID_EN defined -> m_axis_tvalid=0 immediately. After release, ch1 and ch3 requesting gives ch1 first with m_axis_tid=1, then ch3 with m_axis_tid=3.

Source files
------------

// File: rtl/cross_bar_arbiter_rr_mx1.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_arbiter_rr_mx1
// Brief    : Packet-level round-robin Mx1 AXI-Stream arbiter with a one-cycle
//            lookahead grant and a registered 2-entry skid output stage.
//            Define CROSS_BAR_ARB_TID_EN to add the m_axis_tid source tag.
// Revision : 1.0 - initial release
// ============================================================================
module cross_bar_arbiter_rr_mx1 #(
  parameter int CHANNEL_NO = 4,
  parameter int MSEL_WIDTH = $clog2(CHANNEL_NO),
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [CHANNEL_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNEL_NO-1:0]                 s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0]                 s_axis_tlast,
  output logic [CHANNEL_NO-1:0]                 s_axis_tready,
  output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
`ifdef CROSS_BAR_ARB_TID_EN
  output logic [MSEL_WIDTH-1:0]                 m_axis_tid,
`endif
  input  logic                                  m_axis_tready
);

`ifdef CROSS_BAR_ARB_TID_EN
  localparam int C_ENTRY_W = DATA_WIDTH + 1 + MSEL_WIDTH;
`else
  localparam int C_ENTRY_W = DATA_WIDTH + 1;
`endif
  localparam logic [MSEL_WIDTH-1:0] C_PTR_RST = MSEL_WIDTH'(CHANNEL_NO - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [MSEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [MSEL_WIDTH-1:0]   grant_q, grant_d;
  logic [CHANNEL_NO-1:0]   sel_q, sel_d;

  logic [1:0]              count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic [C_ENTRY_W-1:0]    head_q, head_d;
  logic [C_ENTRY_W-1:0]    tail_q, tail_d;

  logic [CHANNEL_NO-1:0]   w_req_hi;
  logic [CHANNEL_NO-1:0]   w_pick;
  logic [MSEL_WIDTH-1:0]   w_nxt_idx;
  logic [CHANNEL_NO-1:0]   w_nxt_sel;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_last;
  logic                    w_sel_valid;
  logic                    w_push;
  logic                    w_pop;
  logic [C_ENTRY_W-1:0]    w_push_entry;

  // Lookahead search: requesters above ptr win, otherwise wrap to the lowest.
  always_comb begin
    w_req_hi  = '0;
    w_nxt_idx = '0;
    w_nxt_sel = '0;
    for (int c = 0; c < CHANNEL_NO; c++) begin
      w_req_hi[c] = s_axis_tvalid[c] && (c > int'(ptr_q));
    end
    w_pick = (|w_req_hi) ? w_req_hi : s_axis_tvalid;
    for (int c = CHANNEL_NO - 1; c >= 0; c--) begin
      if (w_pick[c]) begin
        w_nxt_idx    = MSEL_WIDTH'(c);
        w_nxt_sel    = '0;
        w_nxt_sel[c] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int c = 0; c < CHANNEL_NO; c++) begin
      if (sel_q[c]) begin
        w_sel_data  = w_sel_data | s_axis_tdata[c];
        w_sel_last  = w_sel_last | s_axis_tlast[c];
        w_sel_valid = w_sel_valid | s_axis_tvalid[c];
      end
    end
  end

  // Ready comes only from registers so there is no path from m_axis_tready.
  assign s_axis_tready = (state_q == ST_ACTIVE && ready_q) ? sel_q : '0;
  assign w_push        = (state_q == ST_ACTIVE) && ready_q && w_sel_valid;
  assign w_pop         = valid_q && m_axis_tready;

`ifdef CROSS_BAR_ARB_TID_EN
  assign w_push_entry = {grant_q, w_sel_last, w_sel_data};
  assign m_axis_tid   = head_q[C_ENTRY_W-1 -: MSEL_WIDTH];
`else
  assign w_push_entry = {w_sel_last, w_sel_data};
`endif
  assign m_axis_tdata  = head_q[DATA_WIDTH-1:0];
  assign m_axis_tlast  = head_q[DATA_WIDTH];
  assign m_axis_tvalid = valid_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = w_nxt_idx;
          sel_d   = w_nxt_sel;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_push && w_sel_last) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = C_PTR_RST;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  // Head is the visible output register; tail only fills under backpressure.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (w_push) begin
          head_d  = w_push_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          head_d = w_push_entry;
        end else if (w_push) begin
          tail_d  = w_push_entry;
          count_d = 2'd2;
        end else if (w_pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (w_pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= C_PTR_RST;
      grant_q <= '0;
      sel_q   <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule
`default_nettype wire
